// File: rtl/button_event_pkg.sv
// Shared constants for the push-button front end: FSM encoding and channel indices.
package button_event_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } btn_state_e;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_MIDDLE = 4;
    localparam int BTN_COUNT  = 5;

    // Directional buttons auto-repeat, middle does not.
    localparam logic [BTN_COUNT-1:0] DEFAULT_REPEAT_MASK = 5'b01111;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop sync, debounce, press/auto-repeat FSM, sticky pressed/overrun flags.
// Level settles 2+DEBOUNCE_CYCLES-1 edges after input; pulse shares the level edge; no backpressure.
module button_channel
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic ack,
    output logic btn_level,
    output logic pulse,
    output logic pressed,
    output logic overrun
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic          r_sync1, r_sync2, r_level;
    logic [DW-1:0] r_dcnt, w_dcnt_nxt;
    logic          w_level_nxt;
    btn_state_e    r_state, w_state_nxt;
    logic [RW-1:0] r_rcnt, w_rcnt_nxt;
    logic          r_pulse, w_pulse_nxt;
    logic          r_pressed, r_overrun;

    always_comb begin
        w_level_nxt = r_level;
        w_dcnt_nxt  = '0;
        if (r_sync2 != r_level) begin
            if (r_dcnt == D_LAST) begin
                w_level_nxt = r_sync2;
            end else begin
                w_dcnt_nxt = r_dcnt + 1'b1;
            end
        end
    end

    // FSM looks at the next debounced level so the pulse lands on the same edge as the level change.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_level_nxt) begin
                    w_pulse_nxt = 1'b1;
                    w_state_nxt = HOLD_DELAY;
                    w_rcnt_nxt  = '0;
                end
            end
            HOLD_DELAY: begin
                if (!w_level_nxt) begin
                    w_state_nxt = RELEASED;
                    w_rcnt_nxt  = '0;
                end else if (REPEAT_EN) begin
                    if (r_rcnt == RD_LAST) begin
                        w_pulse_nxt = 1'b1;
                        w_state_nxt = HOLD_REPEAT;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                    end
                end
            end
            HOLD_REPEAT: begin
                if (!w_level_nxt) begin
                    w_state_nxt = RELEASED;
                    w_rcnt_nxt  = '0;
                end else if (r_rcnt == RP_LAST) begin
                    w_pulse_nxt = 1'b1;
                    w_rcnt_nxt  = '0;
                end else begin
                    w_rcnt_nxt = r_rcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_rcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_dcnt  <= '0;
            r_state <= RELEASED;
            r_rcnt  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_level <= w_level_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // A pulse coinciding with ack still latches pressed so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pressed <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_pulse) begin
            r_pressed <= 1'b1;
            if (ack) begin
                r_overrun <= 1'b0;
            end else if (r_pressed) begin
                r_overrun <= 1'b1;
            end
        end else if (ack) begin
            r_pressed <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign btn_level = r_level;
    assign pulse     = r_pulse;
    assign pressed   = r_pressed;
    assign overrun   = r_overrun;

endmodule

// File: rtl/button_event_unit.sv
// N independent button channels between the board pins and the game logic.
// Latency and flag behaviour are those of button_channel; events never stall.
module button_event_unit
    import button_event_pkg::*;
#(
    parameter int             N               = 5,
    parameter int             DEBOUNCE_CYCLES = 250000,
    parameter logic [N-1:0]   REPEAT_MASK     = N'(DEFAULT_REPEAT_MASK),
    parameter int             REPEAT_DELAY    = 12500000,
    parameter int             REPEAT_PERIOD   = 2500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_in,
    input  logic [N-1:0] ack,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] pulse,
    output logic [N-1:0] pressed,
    output logic [N-1:0] overrun
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_MASK[g]),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn_in    (btn_in[g]),
            .ack       (ack[g]),
            .btn_level (btn_level[g]),
            .pulse     (pulse[g]),
            .pressed   (pressed[g]),
            .overrun   (overrun[g])
        );
    end

endmodule

// File: tb/tb_button_event_unit.sv
// Directed test-plan steps followed by a random phase, all checked every cycle against a reference model.
module tb_button_event_unit;
    import button_event_pkg::*;

    localparam int N    = 5;
    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam logic [N-1:0] MASK = 5'b01111;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] ack;
    logic [N-1:0] btn_level, pulse, pressed, overrun;

    int tests = 0;
    int fails = 0;
    int pcnt[N];
    int run_left[N];

    // Reference model: windowed debounce, press-age based repeat, sticky rules.
    logic [N-1:0]   m_d1, m_d2, m_lvl, m_pulse, m_pr, m_ov;
    logic [DEB-1:0] m_win[N];
    int             m_age[N];

    always #5 clk = ~clk;

    button_event_unit #(
        .N(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_MASK(MASK),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .ack(ack),
        .btn_level(btn_level), .pulse(pulse), .pressed(pressed), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pulse = '0; m_pr = '0; m_ov = '0;
        for (int i = 0; i < N; i++) begin
            m_win[i] = '0;
            m_age[i] = -1;
        end
    endtask

    task automatic model_edge();
        logic old_lvl;
        if (reset) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_pulse[i]) begin
                    if (ack[i]) m_ov[i] = 1'b0;
                    else if (m_pr[i]) m_ov[i] = 1'b1;
                    m_pr[i] = 1'b1;
                end else if (ack[i]) begin
                    m_pr[i] = 1'b0;
                    m_ov[i] = 1'b0;
                end
                m_win[i] = {m_win[i][DEB-2:0], m_d2[i]};
                old_lvl = m_lvl[i];
                if (m_win[i] == {DEB{~old_lvl}}) m_lvl[i] = ~old_lvl;
                m_pulse[i] = 1'b0;
                if (!old_lvl && m_lvl[i]) begin
                    m_pulse[i] = 1'b1;
                    m_age[i] = 0;
                end else if (old_lvl && m_lvl[i]) begin
                    m_age[i]++;
                    if (MASK[i] && (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)))
                        m_pulse[i] = 1'b1;
                end else begin
                    m_age[i] = -1;
                end
            end
            m_d2 = m_d1;
            m_d1 = btn_in;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("model_level", btn_level, m_lvl);
        check("model_pulse", pulse, m_pulse);
        check("model_pressed", pressed, m_pr);
        check("model_overrun", overrun, m_ov);
        for (int i = 0; i < N; i++) pcnt[i] += int'(pulse[i]);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < N; i++) pcnt[i] = 0;
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = '0;
        ack    = '0;
        model_clear();
        clr_cnt();
        run(3);
        reset = 1'b0;
        check("reset_level", btn_level, '0);
        check("reset_pulse", pulse, '0);
        check("reset_pressed", pressed, '0);
        check("reset_overrun", overrun, '0);
        run(4);

        // 1: clean press / release on right
        clr_cnt();
        btn_in[BTN_RIGHT] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            cyc();
            if (j == 4) check_int("t1_level_e4", int'(btn_level[BTN_RIGHT]), 0);
            if (j == 5) check_int("t1_level_e5", int'(btn_level[BTN_RIGHT]), 1);
            if (j == 5) check_int("t1_pulse_e5", int'(pulse[BTN_RIGHT]), 1);
            if (j == 6) check_int("t1_pulse_e6", int'(pulse[BTN_RIGHT]), 0);
            if (j == 6) check_int("t1_pressed_e6", int'(pressed[BTN_RIGHT]), 1);
        end
        btn_in[BTN_RIGHT] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            cyc();
            if (j == 4) check_int("t1_rel_e4", int'(btn_level[BTN_RIGHT]), 1);
            if (j == 5) check_int("t1_rel_e5", int'(btn_level[BTN_RIGHT]), 0);
        end
        check_int("t1_pulse_count", pcnt[BTN_RIGHT], 1);

        // 2: glitch rejection on left
        clr_cnt();
        for (int j = 0; j < 9; j++) begin
            btn_in[BTN_LEFT] = (j < 3 || j >= 6);
            cyc();
        end
        btn_in[BTN_LEFT] = 1'b0;
        run(10);
        check_int("t2_pulse_count", pcnt[BTN_LEFT], 0);
        check_int("t2_pressed", int'(pressed[BTN_LEFT]), 0);
        check_int("t2_level", int'(btn_level[BTN_LEFT]), 0);

        // 3: auto-repeat on up; repeat due at the release edge is suppressed
        clr_cnt();
        btn_in[BTN_UP] = 1'b1;
        for (int j = 0; j < 60; j++) begin
            cyc();
            if (j == 5)  check_int("t3_press_pulse", int'(pulse[BTN_UP]), 1);
            if (j == 24) check_int("t3_no_early_repeat", int'(pulse[BTN_UP]), 0);
            if (j == 25) check_int("t3_first_repeat", int'(pulse[BTN_UP]), 1);
            if (j == 33) check_int("t3_second_repeat", int'(pulse[BTN_UP]), 1);
        end
        btn_in[BTN_UP] = 1'b0;
        run(15);
        check_int("t3_pulse_count", pcnt[BTN_UP], 6);
        check_int("t3_level_released", int'(btn_level[BTN_UP]), 0);

        // 4: no repeat on middle; ack and re-press
        clr_cnt();
        btn_in[BTN_MIDDLE] = 1'b1;
        run(60);
        btn_in[BTN_MIDDLE] = 1'b0;
        run(10);
        check_int("t4_pulse_count", pcnt[BTN_MIDDLE], 1);
        check_int("t4_pressed_before_ack", int'(pressed[BTN_MIDDLE]), 1);
        ack[BTN_MIDDLE] = 1'b1;
        cyc();
        ack[BTN_MIDDLE] = 1'b0;
        check_int("t4_pressed_after_ack", int'(pressed[BTN_MIDDLE]), 0);
        btn_in[BTN_MIDDLE] = 1'b1;
        run(10);
        check_int("t4_pressed_repress", int'(pressed[BTN_MIDDLE]), 1);
        btn_in[BTN_MIDDLE] = 1'b0;
        run(10);

        // 5: overrun on down, then ack coinciding with a pulse
        for (int p = 0; p < 2; p++) begin
            btn_in[BTN_DOWN] = 1'b1;
            run(8);
            btn_in[BTN_DOWN] = 1'b0;
            run(8);
        end
        check_int("t5_overrun", int'(overrun[BTN_DOWN]), 1);
        check_int("t5_pressed", int'(pressed[BTN_DOWN]), 1);
        btn_in[BTN_DOWN] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            cyc();
            if (j == 5) check_int("t5_third_pulse", int'(pulse[BTN_DOWN]), 1);
            if (j == 6) check_int("t5_same_cycle_pressed", int'(pressed[BTN_DOWN]), 1);
            if (j == 6) check_int("t5_same_cycle_overrun", int'(overrun[BTN_DOWN]), 0);
            ack[BTN_DOWN] = (j == 5);
        end
        btn_in[BTN_DOWN] = 1'b0;
        run(8);

        // 6: reset mid-debounce and mid-repeat on left
        btn_in[BTN_LEFT] = 1'b1;
        run(4);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t6_rst1_level", btn_level, '0);
        check("t6_rst1_pulse", pulse, '0);
        check("t6_rst1_pressed", pressed, '0);
        check("t6_rst1_overrun", overrun, '0);
        for (int j = 1; j <= 8; j++) begin
            cyc();
            if (j == 5) check_int("t6_no_early_pulse", int'(pulse[BTN_LEFT]), 0);
            if (j == 6) check_int("t6_fresh_pulse", int'(pulse[BTN_LEFT]), 1);
        end
        run(25);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t6_rst2_level", btn_level, '0);
        check("t6_rst2_pulse", pulse, '0);
        check("t6_rst2_pressed", pressed, '0);
        check("t6_rst2_overrun", overrun, '0);
        for (int j = 1; j <= 8; j++) begin
            cyc();
            if (j == 6) check_int("t6_pulse_after_rst2", int'(pulse[BTN_LEFT]), 1);
        end
        btn_in[BTN_LEFT] = 1'b0;
        run(10);

        // Random phase: varied hold/bounce lengths, random acks, occasional reset
        for (int i = 0; i < N; i++) run_left[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (run_left[i] == 0) begin
                    btn_in[i] = ~btn_in[i];
                    run_left[i] = btn_in[i] ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 12));
                end else begin
                    run_left[i]--;
                end
                ack[i] = ($urandom_range(0, 7) == 0);
            end
            reset = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_event_unit.md
Name: button_event_unit

Overview:
Parametrised N-channel front end for the board push-buttons: left, right, up, down and middle on the Minesweeper board. It generalises the single sticky "pressed" / pr_reset pair into per-channel logic:
- synchronisation and debounce
- one-cycle press pulses
- configurable auto-repeat for held directional buttons
- sticky press flags with per-channel acknowledge and an overrun indication

It sits between the board pins and the VGAController game logic.

Parameters:
N, 5, number of button channels (bit order: 0=left, 1=right, 2=up, 3=down, 4=middle)
DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles needed to accept a level change (minimum 1)
REPEAT_MASK, 5'b01111, bit i=1 enables auto-repeat on channel i
REPEAT_DELAY, 12500000, cycles from the press pulse to the first repeat pulse (minimum 1)
REPEAT_PERIOD, 2500000, cycles between subsequent repeat pulses (minimum 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_in  input  N  raw asynchronous button levels, 1 = pressed
ack  input  N  bit i clears pressed[i] and overrun[i] (same role as pr_reset)
btn_level  output  N  debounced level
pulse  output  N  one-cycle event on each press and each repeat
pressed  output  N  sticky: an event occurred on channel i since the last ack
overrun  output  N  sticky: an event arrived while pressed[i] was already 1

Behaviour:
- Reset is synchronous: every flop, counter, synchroniser and FSM clears on the clk edge with reset=1. All outputs are 0 the cycle after. Reset mid-press discards all in-progress counts.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- Synchroniser: 2 flops per channel (sync).
- Debounce:
  - Counter dcnt, width $clog2(DEBOUNCE_CYCLES+1).
  - If sync == btn_level, dcnt clears.
  - Otherwise dcnt increments. When dcnt reaches DEBOUNCE_CYCLES-1 and sync still differs, btn_level toggles and dcnt clears.
  - Any bounce back clears dcnt, so glitches shorter than DEBOUNCE_CYCLES never change btn_level.
- Latency: btn_in held from edge k (first sampling edge) gives btn_level=1 after edge k+2+DEBOUNCE_CYCLES-1. Release is symmetric.
- Event FSM per channel. States are RELEASED, HOLD_DELAY, HOLD_REPEAT.
  - RELEASED: on btn_level 0->1, pulse=1 for exactly one cycle. Go to HOLD_DELAY with rcnt=0.
  - HOLD_DELAY: if btn_level=0, go to RELEASED. Else if REPEAT_MASK[i]=0, stay with no further pulses. Else rcnt increments; at rcnt=REPEAT_DELAY-1, pulse and go to HOLD_REPEAT with rcnt=0.
  - HOLD_REPEAT: if btn_level=0, go to RELEASED. Else pulse every REPEAT_PERIOD cycles (at rcnt=REPEAT_PERIOD-1, then rcnt wraps to 0).
  - Release takes precedence over a repeat pulse due in the same cycle: no pulse.
  - Counter widths are sized by $clog2 of the larger of REPEAT_DELAY and REPEAT_PERIOD. No wrap-around beyond the terminal count.
- Sticky flags:
  - pulse[i] sets pressed[i]; ack[i] clears it.
  - pulse[i] and ack[i] in the same cycle: pressed[i]=1 (event never lost) and overrun[i] clears.
  - pulse[i] while pressed[i]=1 and ack[i]=0: overrun[i]=1.
  - ack held high keeps the flags clear except for the same-cycle set rule.
- pulse, pressed and overrun are registered outputs. pulse appears in the same cycle as the btn_level transition that causes it. pressed follows one cycle after pulse.

Decomposition:
- Package button_event_pkg:
  - state encoding localparams: RELEASED=2'd0, HOLD_DELAY=2'd1, HOLD_REPEAT=2'd2
  - channel index constants: BTN_LEFT..BTN_MIDDLE
  - a default REPEAT_MASK constant
- Sub-module button_channel: synchroniser, debounce counter, event FSM and sticky flags for one channel, with parameter REPEAT_EN.
- button_event_unit is a generate loop over N instances of button_channel.

Test Plan:
Bench parameters: N=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
1. Clean press: btn_in[1]=1 held 10 cycles from edge 0 -> btn_level[1]=1 after edge 5. pulse[1]=1 for exactly 1 cycle, pressed[1]=1 next cycle. Release -> btn_level[1]=0 after 5 edges, no pulse.
2. Glitch rejection: btn_in[0] high for 3 cycles, low 3, high 3 -> btn_level, pulse and pressed all stay 0.
3. Auto-repeat: hold btn_in[2] for 60 cycles -> pulses at press, +20, +28, +36, +44, +52. Release -> pulses stop, state returns to RELEASED.
4. No repeat on middle: hold btn_in[4] for 60 cycles -> exactly 1 pulse. ack[4] pulse -> pressed[4]=0. Second press -> pressed[4]=1 again.
5. Sticky/overrun: two presses on channel 3 without ack -> overrun[3]=1. Ack in the same cycle as a third pulse -> pressed[3]=1, overrun[3]=0.
6. Reset mid-operation: assert reset at the 3rd debounce cycle and again during HOLD_REPEAT -> all outputs 0 the next cycle. A fresh debounce of a full 4 cycles is required before the next pulse.
